cache_controller: RTL and testbench

CACHE_CONTROLLER -- requirements
Module: cache_controller

---
 rtl/cache_pkg.sv | 20 ++
 rtl/cache_way.sv | 54 +++++
 rtl/cache_controller.sv | 151 +++++++++++++++
 tb/tb_cache_controller.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and address-field constants for the 2-way set-associative cache controller.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_MISS,
    WR_THRU,
    RESP
  } state_e;

  localparam int INDEX_W       = 6;
  localparam int TAG_W_DEFAULT = 10;
  localparam int WORD_W        = 32;
  localparam int LINE_W        = 64;

  // Byte address layout: [2] word-in-line, [INDEX_LSB +: index width] set, tag directly above.
  localparam int WORD_SEL_BIT  = 2;
  localparam int INDEX_LSB     = 3;

endpackage

// File: rtl/cache_way.sv
// One cache way: per-set valid bit, tag and 64-bit line, with a single shared index and hit compare.
module cache_way
  import cache_pkg::*;
#(
  parameter int SET_COUNT = 1 << INDEX_W,
  parameter int TAG_W     = TAG_W_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [$clog2(SET_COUNT)-1:0] index,
  input  logic [TAG_W-1:0]             tag,
  output logic                         hit,
  output logic                         valid,
  output logic [LINE_W-1:0]            line,
  input  logic                         fill_en,
  input  logic [TAG_W-1:0]             fill_tag,
  input  logic [LINE_W-1:0]            fill_line,
  input  logic                         inval_en,
  input  logic                         upd_en,
  input  logic                         upd_word_sel,
  input  logic [WORD_W-1:0]            upd_word
);

  logic [SET_COUNT-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [SET_COUNT];
  logic [LINE_W-1:0]    data_q [SET_COUNT];

  assign valid = valid_q[index];
  assign hit   = valid_q[index] && (tag_q[index] == tag);
  assign line  = data_q[index];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[index] <= 1'b1;
    end else if (inval_en) begin
      valid_q[index] <= 1'b0;
    end
  end

  // NOTE: only the valid bits are reset; tag and data are always qualified by valid,
  // so leaving the arrays unreset lets them map onto plain RAM.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[index]  <= fill_tag;
      data_q[index] <= fill_line;
    end else if (upd_en) begin
      if (upd_word_sel) data_q[index][63:32] <= upd_word;
      else              data_q[index][31:0]  <= upd_word;
    end
  end

endmodule

// File: rtl/cache_controller.sv
// 2-way set-associative, write-through/no-write-allocate cache controller in front of an SRAM controller.
// Build option CACHE_WRITE_UPDATE_EN: write hits update the cached word instead of invalidating the line.
module cache_controller
  import cache_pkg::*;
#(
  parameter int SET_COUNT = 1 << INDEX_W,
  parameter int TAG_W     = TAG_W_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd_en,
  input  logic        mem_wr_en,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_write_data,
  output logic [31:0] mem_read_data,
  output logic        mem_ready,
  output logic        sram_rd_en,
  output logic        sram_wr_en,
  output logic [31:0] sram_address,
  output logic [31:0] sram_write_data,
  input  logic [63:0] sram_read_data,
  input  logic        sram_ready
);

  localparam int IDX_W  = $clog2(SET_COUNT);
  localparam int TAG_LO = INDEX_LSB + IDX_W;

  state_e               state;
  logic [31:0]          addr_q;
  logic [31:0]          data_q;
  logic [31:0]          rdata_q;
  logic [SET_COUNT-1:0] lru_q;   // per set: the way to replace next

  logic [IDX_W-1:0]  cur_index, reg_index, way_index;
  logic [TAG_W-1:0]  cur_tag, reg_tag;
  logic [1:0]        hit, valid, fill_en, inval_en, upd_en;
  logic [LINE_W-1:0] line [2];
  logic [LINE_W-1:0] hit_line;
  logic              any_hit, hit_way, victim, is_read, fill_now, write_req;
  logic              unused_addr;

  assign cur_index   = mem_address[INDEX_LSB +: IDX_W];
  assign cur_tag     = mem_address[TAG_LO +: TAG_W];
  assign reg_index   = addr_q[INDEX_LSB +: IDX_W];
  assign reg_tag     = addr_q[TAG_LO +: TAG_W];
  assign unused_addr = ^{mem_address[31:TAG_LO+TAG_W], mem_address[1:0]};

  // Lookups in IDLE see the live request; in-flight work only touches the registered set.
  assign way_index = (state == IDLE) ? cur_index : reg_index;

  // A simultaneous read and write is treated as a write.
  assign is_read   = mem_rd_en & ~mem_wr_en;
  assign write_req = (state == IDLE) & mem_wr_en;
  assign any_hit   = |hit;
  assign hit_way   = ~hit[0];
  assign hit_line  = hit[0] ? line[0] : line[1];
  assign victim    = !valid[0] ? 1'b0 : !valid[1] ? 1'b1 : lru_q[reg_index];
  assign fill_now  = (state == RD_MISS) & sram_ready;
  assign fill_en   = {fill_now & victim, fill_now & ~victim};

`ifdef CACHE_WRITE_UPDATE_EN
  assign upd_en   = {2{write_req}} & hit;
  assign inval_en = 2'b00;
`else
  assign upd_en   = 2'b00;
  assign inval_en = {2{write_req}} & hit;
`endif

  for (genvar w = 0; w < 2; w++) begin : g_way
    cache_way #(
      .SET_COUNT(SET_COUNT),
      .TAG_W    (TAG_W)
    ) u_way (
      .clk         (clk),
      .rst         (rst),
      .index       (way_index),
      .tag         (cur_tag),
      .hit         (hit[w]),
      .valid       (valid[w]),
      .line        (line[w]),
      .fill_en     (fill_en[w]),
      .fill_tag    (reg_tag),
      .fill_line   (sram_read_data),
      .inval_en    (inval_en[w]),
      .upd_en      (upd_en[w]),
      .upd_word_sel(mem_address[WORD_SEL_BIT]),
      .upd_word    (mem_write_data)
    );
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      lru_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_wr_en) begin
            addr_q <= mem_address;
            data_q <= mem_write_data;
            state  <= WR_THRU;
`ifdef CACHE_WRITE_UPDATE_EN
            if (any_hit) lru_q[cur_index] <= ~hit_way;
`endif
          end else if (is_read) begin
            if (any_hit) begin
              lru_q[cur_index] <= ~hit_way;
            end else begin
              addr_q <= mem_address;
              state  <= RD_MISS;
            end
          end
        end
        RD_MISS: begin
          if (sram_ready) begin
            lru_q[reg_index] <= ~victim;
            rdata_q <= addr_q[WORD_SEL_BIT] ? sram_read_data[63:32] : sram_read_data[31:0];
            state   <= RESP;
          end
        end
        WR_THRU: if (sram_ready) state <= RESP;
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: defaults first so every path assigns and no latch is inferred.
  always_comb begin
    mem_ready     = 1'b0;
    mem_read_data = rdata_q;
    case (state)
      IDLE: begin
        mem_ready     = ~mem_wr_en & ~(is_read & ~any_hit);
        mem_read_data = mem_address[WORD_SEL_BIT] ? hit_line[63:32] : hit_line[31:0];
      end
      RESP:    mem_ready = 1'b1;
      default: ;
    endcase
  end

  assign sram_rd_en      = (state == RD_MISS);
  assign sram_wr_en      = (state == WR_THRU);
  assign sram_address    = addr_q;
  assign sram_write_data = data_q;

endmodule

// File: tb/tb_cache_controller.sv
// Randomized self-checking bench: SRAM behaviour and cache contents are modelled with plain arrays.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_rd_en = 1'b0, mem_wr_en = 1'b0;
  logic [31:0] mem_address = '0, mem_write_data = '0;
  logic [31:0] mem_read_data;
  logic        mem_ready;
  logic        sram_rd_en, sram_wr_en;
  logic [31:0] sram_address, sram_write_data;
  logic [63:0] sram_read_data = '0;
  logic        sram_ready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  // Backing store (line address -> 64-bit line) and abstract cache state.
  logic [63:0] mem_model [int unsigned];
  bit          mv   [64][2];
  logic [9:0]  mt   [64][2];
  bit          mlru [64];

  cache_controller dut (
    .clk            (clk),
    .rst            (rst),
    .mem_rd_en      (mem_rd_en),
    .mem_wr_en      (mem_wr_en),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data),
    .mem_ready      (mem_ready),
    .sram_rd_en     (sram_rd_en),
    .sram_wr_en     (sram_wr_en),
    .sram_address   (sram_address),
    .sram_write_data(sram_write_data),
    .sram_read_data (sram_read_data),
    .sram_ready     (sram_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mem_get(input logic [31:0] addr);
    int unsigned key = addr >> 3;
    if (mem_model.exists(key)) return mem_model[key];
    return {key ^ 32'h5A5A_0F0F, ~key};
  endfunction

  function automatic void mem_put(input logic [31:0] addr, input logic [31:0] data);
    logic [63:0] l = mem_get(addr);
    if (addr[2]) l[63:32] = data;
    else         l[31:0]  = data;
    mem_model[addr >> 3] = l;
  endfunction

  function automatic int model_find(input logic [31:0] addr);
    for (int w = 0; w < 2; w++)
      if (mv[addr[8:3]][w] && mt[addr[8:3]][w] == addr[18:9]) return w;
    return -1;
  endfunction

  function automatic void model_fill(input logic [31:0] addr);
    int s = addr[8:3];
    int v;
    if (!mv[s][0])      v = 0;
    else if (!mv[s][1]) v = 1;
    else                v = mlru[s];
    mv[s][v] = 1'b1;
    mt[s][v] = addr[18:9];
    mlru[s]  = (v == 0);
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 64; s++) begin
      mv[s][0] = 1'b0;
      mv[s][1] = 1'b0;
      mlru[s]  = 1'b0;
    end
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [9:0] t = 10'($urandom_range(0, 3));
    logic [5:0] s = 6'($urandom_range(8, 9));
    logic       w = 1'($urandom_range(0, 1));
    return {13'b0, t, s, w, 2'b00};
  endfunction

  // Serves one SRAM transaction of random latency; checks the request is held throughout.
  task automatic sram_serve(input bit is_wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [63:0] rline);
    int lat = $urandom_range(1, 4);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      check(is_wr ? "wr_sram_en" : "rd_sram_en", is_wr ? sram_wr_en : sram_rd_en, 1);
      check(is_wr ? "wr_other_en" : "rd_other_en", is_wr ? sram_rd_en : sram_wr_en, 0);
      check("sram_addr", sram_address, addr);
      if (is_wr) check("sram_wdata", sram_write_data, wdata);
      check("stall", mem_ready, 0);
      sram_ready     = (k == lat);
      sram_read_data = (k == lat) ? rline : {$urandom, $urandom};
      @(posedge clk); #1;
      sram_ready = 1'b0;
    end
  endtask

  task automatic read_op(input logic [31:0] addr, output bit hit_seen);
    int          w = model_find(addr);
    logic [63:0] l = mem_get(addr);
    logic [31:0] exp_word = addr[2] ? l[63:32] : l[31:0];
    mem_address = addr; mem_rd_en = 1'b1; mem_wr_en = 1'b0; mem_write_data = $urandom;
    @(negedge clk);
    hit_seen = mem_ready;
    check("rd_ready_c0", mem_ready, w >= 0);
    check("rd_no_sram_c0", {sram_rd_en, sram_wr_en}, 0);
    if (w >= 0) begin
      check("rd_hit_data", mem_read_data, exp_word);
      mlru[addr[8:3]] = (w == 0);
      @(posedge clk); #1;
    end else begin
      @(posedge clk); #1;
      mem_rd_en   = 1'($urandom_range(0, 1));
      mem_address = $urandom;
      sram_serve(1'b0, addr, 32'h0, l);
      @(negedge clk);
      check("rd_resp_ready", mem_ready, 1);
      check("rd_resp_data", mem_read_data, exp_word);
      check("rd_resp_no_sram", {sram_rd_en, sram_wr_en}, 0);
      model_fill(addr);
      @(posedge clk); #1;
    end
  endtask

  task automatic write_op(input logic [31:0] addr, input logic [31:0] data);
    int w = model_find(addr);
    mem_address = addr; mem_write_data = data; mem_wr_en = 1'b1;
    mem_rd_en = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("wr_stall_c0", mem_ready, 0);
    check("wr_no_sram_c0", {sram_rd_en, sram_wr_en}, 0);
    if (w >= 0) begin
`ifdef CACHE_WRITE_UPDATE_EN
      mlru[addr[8:3]] = (w == 0);
`else
      mv[addr[8:3]][w] = 1'b0;
`endif
    end
    mem_put(addr, data);
    @(posedge clk); #1;
    mem_wr_en = 1'($urandom_range(0, 1)); mem_rd_en = 1'($urandom_range(0, 1));
    mem_address = $urandom; mem_write_data = $urandom;
    sram_serve(1'b1, addr, data, {$urandom, $urandom});
    @(negedge clk);
    check("wr_resp_ready", mem_ready, 1);
    check("wr_resp_no_sram", {sram_rd_en, sram_wr_en}, 0);
    @(posedge clk); #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    mem_rd_en = 1'b0; mem_wr_en = 1'b0;
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    bit h;
    model_reset();
    #12;
    check("rst_ready", mem_ready, 1);
    check("rst_sram_en", {sram_rd_en, sram_wr_en}, 0);
    check("rst_addr", sram_address, 0);
    #8 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_ready", mem_ready, 1);
    check("idle_sram_en", {sram_rd_en, sram_wr_en}, 0);
    @(posedge clk); #1;

    // Cold miss then same-line hit on the other word.
    mem_model[32'h40 >> 3] = 64'h2222_2222_1111_1111;
    read_op(32'h0000_0040, h);
    check("cold_miss", h, 0);
    read_op(32'h0000_0044, h);
    check("line_hit", h, 1);

    // LRU eviction at set 8: tags 1, 2 filled, tag 1 touched, tag 3 must evict tag 2.
    pulse_reset();
    read_op(32'h0000_0240, h); check("lru_fill1", h, 0);
    read_op(32'h0000_0440, h); check("lru_fill2", h, 0);
    read_op(32'h0000_0240, h); check("lru_touch1", h, 1);
    read_op(32'h0000_0640, h); check("lru_fill3", h, 0);
    read_op(32'h0000_0240, h); check("lru_keep1", h, 1);
    read_op(32'h0000_0440, h); check("lru_evicted2", h, 0);

    // Write-through to a cached word.
    read_op(32'h0000_0040, h);
    write_op(32'h0000_0040, 32'hDEAD_BEEF);
    read_op(32'h0000_0040, h);
`ifdef CACHE_WRITE_UPDATE_EN
    check("wr_hit_then_read", h, 1);
`else
    check("wr_hit_then_read", h, 0);
`endif

    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) < 7) read_op(rand_addr(), h);
      else                         write_op(rand_addr(), $urandom);
    end

    // Reset asserted while a miss is outstanding.
    mem_address = 32'h0000_0A40; mem_rd_en = 1'b1; mem_wr_en = 1'b0;
    @(negedge clk);
    check("rm_miss", mem_ready, 0);
    @(posedge clk); #1;
    mem_rd_en = 1'b0;
    @(negedge clk);
    check("rm_in_flight", sram_rd_en, 1);
    #2 rst = 1'b0;
    #1;
    check("rm_rd_dropped", sram_rd_en, 0);
    check("rm_ready", mem_ready, 1);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    read_op(32'h0000_0A40, h); check("rm_refetch_miss", h, 0);
    read_op(32'h0000_0040, h); check("rm_flushed_miss", h, 0);

    mem_rd_en = 1'b0; mem_wr_en = 1'b0;
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
